// File: rtl/count_mod_n.sv
// count_mod_n: cascadable multi-digit modulo counter (DIGITS digits, each mod MOD).
// Counts up or down, supports a synchronous parallel load, and emits registered
// one-cycle wrap pulses per digit (dig_co) and for the whole counter (co).
// Optional compare output is enabled by defining COUNT_MOD_N_CMP_EN.
module count_mod_n #(
  parameter int DIGITS = 2,
  parameter int MOD    = 10,
  parameter int W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [DIGITS*W-1:0]   load_val,
  output logic [DIGITS*W-1:0]   count,
  output logic [DIGITS-1:0]     dig_co,
  output logic                  co,
  output logic                  load_err
`ifdef COUNT_MOD_N_CMP_EN
  ,
  input  logic [DIGITS*W-1:0]   cmp_val,
  output logic                  match
`endif
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);
  localparam logic [W-1:0] ONE = W'(1);

  logic [DIGITS*W-1:0] count_q, count_d;
  logic [DIGITS-1:0]   dig_co_q, dig_co_d;
  logic                co_q, co_d;
  logic                load_err_q, load_err_d;

  // Next-state: load takes priority over counting; pulses default low each cycle.
  always_comb begin
    logic [W-1:0] digit;
    logic         step;
    count_d    = count_q;
    dig_co_d   = '0;
    co_d       = 1'b0;
    load_err_d = 1'b0;
    digit      = '0;
    step       = 1'b0;
    if (load) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        digit = load_val[k*W +: W];
        if (digit > MAX) begin
          count_d[k*W +: W] = '0;
          load_err_d        = 1'b1;
        end else begin
          count_d[k*W +: W] = digit;
        end
      end
    end else if (en) begin
      // Ripple the step enable from digit 0 upward; a digit steps only when
      // every lower digit sits at its wrap value for the current direction.
      step = 1'b1;
      for (int unsigned k = 0; k < DIGITS; k++) begin
        digit = count_q[k*W +: W];
        if (step) begin
          if (up) begin
            if (digit == MAX) begin
              count_d[k*W +: W] = '0;
              dig_co_d[k]       = 1'b1;
            end else if (digit > MAX) begin
              count_d[k*W +: W] = '0;
            end else begin
              count_d[k*W +: W] = digit + ONE;
            end
          end else begin
            if (digit == '0) begin
              count_d[k*W +: W] = MAX;
              dig_co_d[k]       = 1'b1;
            end else if (digit > MAX) begin
              count_d[k*W +: W] = '0;
            end else begin
              count_d[k*W +: W] = digit - ONE;
            end
          end
        end
        step = step && (up ? (digit == MAX) : (digit == '0));
      end
      // Top digit wrapping implies every lower digit wrapped in the same step.
      co_d = &dig_co_d;
    end
  end

  // State and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      dig_co_q   <= '0;
      co_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dig_co_q   <= dig_co_d;
      co_q       <= co_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign dig_co   = dig_co_q;
  assign co       = co_q;
  assign load_err = load_err_q;

`ifdef COUNT_MOD_N_CMP_EN
  logic match_q, match_d;

  // Registered equality flag: reflects the count value of the previous cycle.
  always_comb begin
    match_d = (count_q == cmp_val);
  end

  // Compare register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_count_mod_n.sv
// Testbench for count_mod_n: directed scenarios plus randomized stimulus,
// checked against an integer-valued reference model of the counter.
module tb_count_mod_n;

  localparam int DIGITS = 2;
  localparam int MOD    = 10;
  localparam int W      = 4;
  localparam int RANGE  = MOD ** DIGITS;

  logic                clk = 1'b0;
  logic                rst, en, up, load;
  logic [DIGITS*W-1:0] load_val;
  logic [DIGITS*W-1:0] count;
  logic [DIGITS-1:0]   dig_co;
  logic                co, load_err;
`ifdef COUNT_MOD_N_CMP_EN
  logic [DIGITS*W-1:0] cmp_val;
  logic                match;
  logic                m_match;
`endif

  int errors = 0;
  int checks = 0;

  int                mval;
  logic [DIGITS-1:0] m_dig;
  logic              m_co, m_lerr;

  always #5 clk = ~clk;

  count_mod_n #(.DIGITS(DIGITS), .MOD(MOD), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .dig_co   (dig_co),
    .co       (co),
    .load_err (load_err)
`ifdef COUNT_MOD_N_CMP_EN
    ,
    .cmp_val  (cmp_val),
    .match    (match)
`endif
  );

  function automatic int pw(int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * MOD;
    return p;
  endfunction

  function automatic logic [DIGITS*W-1:0] to_vec(int v);
    logic [DIGITS*W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[k*W +: W] = W'((v / pw(k)) % MOD);
    return r;
  endfunction

  // Reference model: counter held as a plain integer in 0..RANGE-1.
  task automatic model_edge();
    int prev = mval;
    int d;
    if (rst) begin
      mval = 0; m_dig = '0; m_co = 1'b0; m_lerr = 1'b0;
`ifdef COUNT_MOD_N_CMP_EN
      m_match = 1'b0;
`endif
    end else begin
`ifdef COUNT_MOD_N_CMP_EN
      m_match = (to_vec(prev) == cmp_val);
`endif
      m_dig = '0; m_co = 1'b0; m_lerr = 1'b0;
      if (load) begin
        mval = 0;
        for (int k = 0; k < DIGITS; k++) begin
          d = int'(load_val[k*W +: W]);
          if (d >= MOD) m_lerr = 1'b1;
          else mval = mval + d * pw(k);
        end
      end else if (en) begin
        if (up) begin
          mval = (prev + 1) % RANGE;
          for (int k = 0; k < DIGITS; k++) m_dig[k] = ((mval % pw(k+1)) == 0);
        end else begin
          for (int k = 0; k < DIGITS; k++) m_dig[k] = ((prev % pw(k+1)) == 0);
          mval = (prev + RANGE - 1) % RANGE;
        end
        m_co = m_dig[DIGITS-1];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    tick(); tick();
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %h expected 00", count); end
    checks++; if (dig_co !== '0) begin errors++; $display("FAIL reset_dig_co: got %b expected 00", dig_co); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL reset_co: got %b expected 0", co); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b expected 0", load_err); end
    rst = 1'b0;
  endtask

  task automatic test_up_full();
    int co_cnt = 0, d0_cnt = 0, co_at = -1;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (co === 1'b1) begin co_cnt++; co_at = i; end
      if (dig_co[0] === 1'b1) d0_cnt++;
      checks++; if (count !== to_vec(mval)) begin errors++; $display("FAIL up_count[%0d]: got %h expected %h", i, count, to_vec(mval)); end
      checks++; if (dig_co !== m_dig || co !== m_co) begin errors++; $display("FAIL up_pulses[%0d]: got dig_co=%b co=%b expected dig_co=%b co=%b", i, dig_co, co, m_dig, m_co); end
    end
    checks++; if (co_cnt != 1 || co_at != 99) begin errors++; $display("FAIL up_co_once: got %0d pulses last at %0d expected 1 at 99", co_cnt, co_at); end
    checks++; if (d0_cnt != 10) begin errors++; $display("FAIL up_dig0_pulses: got %0d expected 10", d0_cnt); end
    checks++; if (count !== 8'h00) begin errors++; $display("FAIL up_final: got %h expected 00", count); end
    en = 1'b0;
  endtask

  task automatic test_down();
    load = 1'b1; load_val = 8'h00; en = 1'b0;
    tick();
    checks++; if (count !== 8'h00 || load_err !== 1'b0) begin errors++; $display("FAIL down_load: got %h err=%b expected 00 err=0", count, load_err); end
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick();
    checks++; if (count !== 8'h99 || co !== 1'b1 || dig_co !== 2'b11) begin errors++; $display("FAIL down_wrap: got %h co=%b dig_co=%b expected 99 co=1 dig_co=11", count, co, dig_co); end
    tick();
    checks++; if (count !== 8'h98 || co !== 1'b0 || dig_co !== 2'b00) begin errors++; $display("FAIL down_next: got %h co=%b dig_co=%b expected 98 co=0 dig_co=00", count, co, dig_co); end
    en = 1'b0;
  endtask

  task automatic test_load_err();
    load = 1'b1; load_val = 8'hC7; en = 1'b1; up = 1'b1;
    tick();
    checks++; if (count !== 8'h07) begin errors++; $display("FAIL lerr_count: got %h expected 07", count); end
    checks++; if (load_err !== 1'b1 || co !== 1'b0 || dig_co !== 2'b00) begin errors++; $display("FAIL lerr_pulses: got err=%b co=%b dig_co=%b expected err=1 co=0 dig_co=00", load_err, co, dig_co); end
    load = 1'b0; en = 1'b0;
    tick();
    checks++; if (load_err !== 1'b0 || count !== 8'h07) begin errors++; $display("FAIL lerr_clear: got err=%b count=%h expected err=0 count=07", load_err, count); end
  endtask

  task automatic test_gaps_reversal();
    load = 1'b1; load_val = 8'h09; en = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 8'h09 || dig_co !== 2'b00) begin errors++; $display("FAIL gap_hold[%0d]: got %h dig_co=%b expected 09 dig_co=00", i, count, dig_co); end
    end
    en = 1'b1; up = 1'b1;
    tick();
    checks++; if (count !== 8'h10 || dig_co !== 2'b01 || co !== 1'b0) begin errors++; $display("FAIL rev_up: got %h dig_co=%b co=%b expected 10 dig_co=01 co=0", count, dig_co, co); end
    up = 1'b0;
    tick();
    checks++; if (count !== 8'h09 || dig_co !== 2'b01 || co !== 1'b0) begin errors++; $display("FAIL rev_down: got %h dig_co=%b co=%b expected 09 dig_co=01 co=0", count, dig_co, co); end
    en = 1'b0;
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 8'h98; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    checks++; if (count !== 8'h99) begin errors++; $display("FAIL rmid_pre: got %h expected 99", count); end
    rst = 1'b1;
    tick();
    checks++; if (count !== 8'h00 || co !== 1'b0 || dig_co !== 2'b00 || load_err !== 1'b0) begin errors++; $display("FAIL rmid_post: got %h co=%b dig_co=%b err=%b expected 00 with no pulses", count, co, dig_co, load_err); end
    rst = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 63) == 0);
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < DIGITS; k++) load_val[k*W +: W] = W'($urandom_range(0, 15));
      tick();
      checks++; if (count !== to_vec(mval)) begin errors++; $display("FAIL rand_count[%0d]: got %h expected %h", i, count, to_vec(mval)); end
      checks++; if (dig_co !== m_dig || co !== m_co || load_err !== m_lerr) begin errors++; $display("FAIL rand_pulses[%0d]: got dig_co=%b co=%b err=%b expected dig_co=%b co=%b err=%b", i, dig_co, co, load_err, m_dig, m_co, m_lerr); end
`ifdef COUNT_MOD_N_CMP_EN
      checks++; if (match !== m_match) begin errors++; $display("FAIL rand_match[%0d]: got %b expected %b", i, match, m_match); end
`endif
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

`ifdef COUNT_MOD_N_CMP_EN
  task automatic test_cmp();
    cmp_val = 8'h42;
    load = 1'b1; load_val = 8'h40; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    checks++; if (count !== 8'h41 || match !== 1'b0) begin errors++; $display("FAIL cmp_41: got %h match=%b expected 41 match=0", count, match); end
    tick();
    checks++; if (count !== 8'h42 || match !== 1'b0) begin errors++; $display("FAIL cmp_42: got %h match=%b expected 42 match=0", count, match); end
    tick();
    checks++; if (count !== 8'h43 || match !== 1'b1) begin errors++; $display("FAIL cmp_43: got %h match=%b expected 43 match=1", count, match); end
    tick();
    checks++; if (match !== 1'b0) begin errors++; $display("FAIL cmp_after: got %b expected 0", match); end
    en = 1'b0;
    cmp_val = 8'h17;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    mval = 0; m_dig = '0; m_co = 1'b0; m_lerr = 1'b0;
`ifdef COUNT_MOD_N_CMP_EN
    cmp_val = '0; m_match = 1'b0;
`endif
    test_reset();
    test_up_full();
    test_down();
    test_load_err();
    test_gaps_reversal();
    test_reset_mid();
`ifdef COUNT_MOD_N_CMP_EN
    test_cmp();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_mod_n.md
Name: count_mod_n

Overview:
- Parametrised, cascadable multi-digit modulo counter; successor to the single-digit decade counter with carry.
- Counts DIGITS digits, each modulo MOD, up or down, with synchronous parallel load and registered wrap/borrow pulses.
- Used for timer, display and event-count datapaths.
- Multiple instances chain through en and co.

Parameters:
- DIGITS, 2, number of cascaded digits (1..8).
- MOD, 10, modulus of each digit (2..2^W).
- W, 4, bit width of one digit; 2^W >= MOD is required.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per enabled cycle.
- up  input  1  direction: 1 counts up, 0 counts down; sampled every cycle.
- load  input  1  synchronous parallel load.
- load_val  input  DIGITS*W  load value; digit k at bits [k*W +: W].
- count  output  DIGITS*W  current value; digit k at bits [k*W +: W].
- dig_co  output  DIGITS  per-digit wrap pulse.
- co  output  1  whole-counter wrap/borrow pulse.
- load_err  output  1  pulse flagging an out-of-range load digit.

Behaviour:
- Reset: all outputs (count, dig_co, co, load_err) are 0.
- Priority at each rising edge: rst > load > en. With none active, count holds.
- Pulse outputs: dig_co, co and load_err are registered and high for exactly one cycle. They clear on the next edge regardless of en.
- Load:
  - Each digit takes load_val[k]. A digit value >= MOD loads as 0 instead.
  - load_err = 1 in the cycle after the load if any digit was out of range.
  - No dig_co or co on a load, even if en is also high.
- Count up (en=1, up=1):
  - Digit 0 increments.
  - Digit k (k>0) steps only when digits 0..k-1 are all MOD-1.
  - A digit at MOD-1 that steps goes to 0 and sets its dig_co bit.
- Count down (en=1, up=0):
  - Digit 0 decrements.
  - Digit k steps only when digits 0..k-1 are all 0.
  - A digit at 0 that steps goes to MOD-1 and sets its dig_co bit.
- Whole-counter wrap:
  - Up from all digits MOD-1 gives all 0 and co = 1.
  - Down from all digits 0 gives all MOD-1 and co = 1.
  - co = 1 in the same cycle count shows the wrapped value.
  - co equals dig_co[DIGITS-1] AND'ed with the all-lower-digits-wrapped condition.
- Latency: count, dig_co and co update on the same edge that samples en. There is no combinational path from en to any output.
- Direction reversal is allowed on any cycle and takes effect at that edge. No extra wrap pulse results.
- Arithmetic is per digit, modulo MOD, never binary. Unused encodings (>= MOD) are unreachable except through reset-free X states; such a digit steps to 0 on the next enabled step.
- Reset mid-count: count is 0 next cycle. Pulses pending from the same edge are suppressed.
- Cascading: an upstream co drives a downstream en directly; the downstream block steps one cycle later.

Optional Feature:
- Macro COUNT_MOD_N_CMP_EN.
- Defined:
  - Adds input cmp_val [DIGITS*W] and output match (1 bit).
  - match is registered, reset 0.
  - match = 1 in the cycle after count equals cmp_val; it stays high while they are equal.
- Undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- Basic up count: rst=1 for 2 cycles, then en=1, up=1 for 100 cycles (DIGITS=2, MOD=10). Count steps 00..99 then 00. co pulses exactly once, at the 00 after 99. dig_co[0] pulses 10 times.
- Basic down count: load 00, then en=1, up=0. Next value is 99 with co=1 for one cycle. Next is 98 with co=0.
- Out-of-range load: load=1 with load_val digits {0xC, 0x7}, en=1 in the same cycle. Count = {0, 7}, load_err=1 for one cycle, no co, no increment.
- Enable gaps and reversal: count 09, then en=0 for 3 cycles and count holds at 09. Then en=1, up=1 gives 10 with dig_co[0]=1. Then up=0 gives 09 with dig_co[0]=1 (borrow) and co=0.
- Reset mid-count: reset asserted in the cycle count goes 99 -> 00. Count = 00, co = 0, all pulses 0.
- Compare (COUNT_MOD_N_CMP_EN defined): cmp_val=42, count up from 40. match=0 at 40 and 41. match=1 in the cycle after count reaches 42, while count shows 43 with en held high.
